// File: rtl/lcd_bus_receiver.sv
// ---------------------------------------------------------------------------
// lcd_bus_receiver
// Receiving end of the 8-bit 8080-style LCD write bus. Synchronises the bus
// into the clk_100 domain, detects one write event per lcd_wr rising edge and
// decodes the ILI9341-style command subset (CASET 0x2A, PASET 0x2B, RAMWR 0x2C,
// NOP 0x00, SWRESET 0x01). RGB565 byte pairs written after RAMWR become
// single-cycle pixel writes with x/y coordinates and 4-bit colour levels.
//
// Ports:
//   clk_100     sampling clock (bus is asynchronous to it)
//   resetN      asynchronous active-low reset
//   lcd_db      bus data byte
//   lcd_wr      write strobe, data taken on its rising edge
//   lcd_d_c     0 = command byte, 1 = data/parameter byte
//   lcd_reset   panel reset, active low (synchronised, acts like resetN)
//   pxl_valid   one-cycle pulse per decoded pixel
//   pxl_x/y     pixel column / row (held between pulses)
//   Red/Green/Blue  RGB565 R[4:1], G[5:2], B[4:1] (held between pulses)
//   frame_start one-cycle pulse per accepted 0x2C command
//   cmd_err     one-cycle pulse on unknown command or rejected window
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module lcd_bus_receiver #(
   parameter int WIDTH       = 320,
   parameter int HEIGHT      = 240,
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk_100,
   input  logic        resetN,
   input  logic [7:0]  lcd_db,
   input  logic        lcd_wr,
   input  logic        lcd_d_c,
   input  logic        lcd_reset,
   output logic        pxl_valid,
   output logic [31:0] pxl_x,
   output logic [31:0] pxl_y,
   output logic [3:0]  Red,
   output logic [3:0]  Green,
   output logic [3:0]  Blue,
   output logic        frame_start,
   output logic        cmd_err
);

   localparam logic [15:0] X_MAX = 16'(WIDTH - 1);
   localparam logic [15:0] Y_MAX = 16'(HEIGHT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_CASET, S_PASET, S_RAM_HI, S_RAM_LO, S_SKIP
   } state_t;

   // ---- input synchronisers ----
   // wr/d_c chains reset high so an idle (high) strobe does not look like a
   // fresh rising edge right after reset.
   logic [SYNC_STAGES-1:0] wr_sync, dc_sync, rst_sync;
   logic [7:0]             db_sync [SYNC_STAGES];
   logic                   wr_p1;

   always_ff @(posedge clk_100 or negedge resetN) begin
      if (!resetN) begin
         wr_sync  <= '1;
         dc_sync  <= '1;
         rst_sync <= '0;
         wr_p1    <= 1'b1;
         for (int i = 0; i < SYNC_STAGES; i++) db_sync[i] <= 8'h00;
      end else begin
         wr_sync  <= {wr_sync[SYNC_STAGES-2:0], lcd_wr};
         dc_sync  <= {dc_sync[SYNC_STAGES-2:0], lcd_d_c};
         rst_sync <= {rst_sync[SYNC_STAGES-2:0], lcd_reset};
         wr_p1    <= wr_sync[SYNC_STAGES-1];
         db_sync[0] <= lcd_db;
         for (int i = 1; i < SYNC_STAGES; i++) db_sync[i] <= db_sync[i-1];
      end
   end

   // ---- stage p0: synchronised bus, write event ----
   logic       wr_p0, dc_p0, rstn_p0, vld_p0;
   logic [7:0] db_p0;

   assign wr_p0   = wr_sync[SYNC_STAGES-1];
   assign dc_p0   = dc_sync[SYNC_STAGES-1];
   assign rstn_p0 = rst_sync[SYNC_STAGES-1];
   assign db_p0   = db_sync[SYNC_STAGES-1];
   assign vld_p0  = wr_p0 & ~wr_p1;

   // ---- decoder state ----
   state_t      state, state_n;
   logic [15:0] sc, ec, sp, ep, sc_n, ec_n, sp_n, ep_n;
   logic [15:0] cur_x, cur_y, cur_x_n, cur_y_n;
   logic [1:0]  pidx, pidx_n;
   logic [15:0] sh_start, sh_start_n;
   logic [7:0]  sh_end_hi, sh_end_hi_n;
   // only the high-byte bits that reach the colour fields: {R[4:1], G[5:3]}
   logic [6:0]  hi_byte, hi_byte_n;

   logic        pxl_valid_n, frame_start_n, cmd_err_n;
   logic [31:0] pxl_x_n, pxl_y_n;
   logic [3:0]  red_n, green_n, blue_n;

   logic [15:0] new_end, lim;

   always_comb begin
      state_n       = state;
      sc_n          = sc;
      ec_n          = ec;
      sp_n          = sp;
      ep_n          = ep;
      cur_x_n       = cur_x;
      cur_y_n       = cur_y;
      pidx_n        = pidx;
      sh_start_n    = sh_start;
      sh_end_hi_n   = sh_end_hi;
      hi_byte_n     = hi_byte;
      pxl_valid_n   = 1'b0;
      frame_start_n = 1'b0;
      cmd_err_n     = 1'b0;
      pxl_x_n       = pxl_x;
      pxl_y_n       = pxl_y;
      red_n         = Red;
      green_n       = Green;
      blue_n        = Blue;
      new_end       = {sh_end_hi, db_p0};
      lim           = (state == S_CASET) ? X_MAX : Y_MAX;

      if (!rstn_p0) begin
         // panel reset held low: same effect as resetN, writes ignored
         state_n   = S_IDLE;
         sc_n      = 16'd0;
         ec_n      = X_MAX;
         sp_n      = 16'd0;
         ep_n      = Y_MAX;
         cur_x_n   = 16'd0;
         cur_y_n   = 16'd0;
         pidx_n    = 2'd0;
         pxl_x_n   = 32'd0;
         pxl_y_n   = 32'd0;
         red_n     = 4'd0;
         green_n   = 4'd0;
         blue_n    = 4'd0;
      end else if (vld_p0) begin
         if (!dc_p0) begin
            // a command aborts whatever was in progress
            pidx_n = 2'd0;
            case (db_p0)
               8'h00: state_n = S_IDLE;
               8'h01: begin
                  state_n = S_IDLE;
                  sc_n    = 16'd0;
                  ec_n    = X_MAX;
                  sp_n    = 16'd0;
                  ep_n    = Y_MAX;
                  cur_x_n = 16'd0;
                  cur_y_n = 16'd0;
               end
               8'h2A: state_n = S_CASET;
               8'h2B: state_n = S_PASET;
               8'h2C: begin
                  state_n       = S_RAM_HI;
                  cur_x_n       = sc;
                  cur_y_n       = sp;
                  frame_start_n = 1'b1;
               end
               default: begin
                  state_n   = S_SKIP;
                  cmd_err_n = 1'b1;
               end
            endcase
         end else begin
            case (state)
               S_CASET, S_PASET: begin
                  pidx_n = pidx + 2'd1;
                  case (pidx)
                     2'd0: sh_start_n[15:8] = db_p0;
                     2'd1: sh_start_n[7:0]  = db_p0;
                     2'd2: sh_end_hi_n      = db_p0;
                     default: begin
                        state_n = S_IDLE;
                        if (sh_start <= new_end && new_end <= lim) begin
                           if (state == S_CASET) begin
                              sc_n = sh_start;
                              ec_n = new_end;
                           end else begin
                              sp_n = sh_start;
                              ep_n = new_end;
                           end
                        end else begin
                           cmd_err_n = 1'b1;
                        end
                     end
                  endcase
               end
               S_RAM_HI: begin
                  hi_byte_n = {db_p0[7:4], db_p0[2:0]};
                  state_n   = S_RAM_LO;
               end
               S_RAM_LO: begin
                  pxl_valid_n = 1'b1;
                  pxl_x_n     = {16'd0, cur_x};
                  pxl_y_n     = {16'd0, cur_y};
                  red_n       = hi_byte[6:3];
                  green_n     = {hi_byte[2:0], db_p0[7]};
                  blue_n      = db_p0[4:1];
                  state_n     = S_RAM_HI;
                  // raster advance inside the window, wrapping at the bottom
                  if (cur_x == ec) begin
                     cur_x_n = sc;
                     cur_y_n = (cur_y == ep) ? sp : cur_y + 16'd1;
                  end else begin
                     cur_x_n = cur_x + 16'd1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // ---- stage p1: registered decoder state and outputs ----
   always_ff @(posedge clk_100 or negedge resetN) begin
      if (!resetN) begin
         state       <= S_IDLE;
         sc          <= 16'd0;
         ec          <= X_MAX;
         sp          <= 16'd0;
         ep          <= Y_MAX;
         cur_x       <= 16'd0;
         cur_y       <= 16'd0;
         pidx        <= 2'd0;
         sh_start    <= 16'd0;
         sh_end_hi   <= 8'd0;
         hi_byte     <= 7'd0;
         pxl_valid   <= 1'b0;
         frame_start <= 1'b0;
         cmd_err     <= 1'b0;
         pxl_x       <= 32'd0;
         pxl_y       <= 32'd0;
         Red         <= 4'd0;
         Green       <= 4'd0;
         Blue        <= 4'd0;
      end else begin
         state       <= state_n;
         sc          <= sc_n;
         ec          <= ec_n;
         sp          <= sp_n;
         ep          <= ep_n;
         cur_x       <= cur_x_n;
         cur_y       <= cur_y_n;
         pidx        <= pidx_n;
         sh_start    <= sh_start_n;
         sh_end_hi   <= sh_end_hi_n;
         hi_byte     <= hi_byte_n;
         pxl_valid   <= pxl_valid_n;
         frame_start <= frame_start_n;
         cmd_err     <= cmd_err_n;
         pxl_x       <= pxl_x_n;
         pxl_y       <= pxl_y_n;
         Red         <= red_n;
         Green       <= green_n;
         Blue        <= blue_n;
      end
   end

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// ---------------------------------------------------------------------------
// tb_lcd_bus_receiver
// Directed bench for lcd_bus_receiver: drives 8080-style bus writes, collects
// every pxl_valid / frame_start / cmd_err pulse and compares against
// hand-computed pixel coordinates and colours.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lcd_bus_receiver;

   logic        clk = 1'b0;
   logic        resetN;
   logic [7:0]  lcd_db;
   logic        lcd_wr;
   logic        lcd_d_c;
   logic        lcd_reset;
   logic        pxl_valid;
   logic [31:0] pxl_x, pxl_y;
   logic [3:0]  Red, Green, Blue;
   logic        frame_start, cmd_err;

   always #5 clk = ~clk;

   lcd_bus_receiver #(.WIDTH(320), .HEIGHT(240), .SYNC_STAGES(2)) dut (
      .clk_100     (clk),
      .resetN      (resetN),
      .lcd_db      (lcd_db),
      .lcd_wr      (lcd_wr),
      .lcd_d_c     (lcd_d_c),
      .lcd_reset   (lcd_reset),
      .pxl_valid   (pxl_valid),
      .pxl_x       (pxl_x),
      .pxl_y       (pxl_y),
      .Red         (Red),
      .Green       (Green),
      .Blue        (Blue),
      .frame_start (frame_start),
      .cmd_err     (cmd_err)
   );

   int n_chk = 0;
   int n_err = 0;
   int fs_cnt = 0;
   int err_cnt = 0;
   int fs0, err0, ph;
   logic [31:0] px_x_q [$];
   logic [31:0] px_y_q [$];
   logic [11:0] px_c_q [$];

   // collect pulses away from the active edge
   always @(negedge clk) begin
      if (pxl_valid) begin
         px_x_q.push_back(pxl_x);
         px_y_q.push_back(pxl_y);
         px_c_q.push_back({Red, Green, Blue});
      end
      if (frame_start) fs_cnt++;
      if (cmd_err) err_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic bus_wr(input logic dc, input logic [7:0] d, input int lo = 3, input int hi = 3);
      lcd_d_c = dc;
      lcd_db  = d;
      lcd_wr  = 1'b0;
      #(10 * lo);
      lcd_wr  = 1'b1;
      #(10 * hi);
   endtask

   task automatic align();
      @(posedge clk);
      #(ph);
   endtask

   task automatic settle();
      #60;
   endtask

   task automatic win(input logic [7:0] cmd, input logic [15:0] s, input logic [15:0] e);
      bus_wr(1'b0, cmd);
      bus_wr(1'b1, s[15:8]);
      bus_wr(1'b1, s[7:0]);
      bus_wr(1'b1, e[15:8]);
      bus_wr(1'b1, e[7:0]);
   endtask

   task automatic pix(input logic [15:0] v, input int lo = 3, input int hi = 3);
      bus_wr(1'b1, v[15:8], lo, hi);
      bus_wr(1'b1, v[7:0], lo, hi);
   endtask

   task automatic pop_px(input string tag, input int ex, input int ey, input logic [11:0] ergb);
      chk({tag, "_avail"}, 32'(px_x_q.size() > 0), 32'd1);
      if (px_x_q.size() > 0) begin
         chk({tag, "_x"}, px_x_q.pop_front(), 32'(ex));
         chk({tag, "_y"}, px_y_q.pop_front(), 32'(ey));
         chk({tag, "_rgb"}, {20'd0, px_c_q.pop_front()}, {20'd0, ergb});
      end
   endtask

   initial begin
      ph        = 3;
      resetN    = 1'b0;
      lcd_wr    = 1'b1;
      lcd_d_c   = 1'b1;
      lcd_db    = 8'h00;
      lcd_reset = 1'b1;
      #23;
      chk("rst_valid", {31'd0, pxl_valid}, 32'd0);
      chk("rst_x", pxl_x, 32'd0);
      chk("rst_y", pxl_y, 32'd0);
      chk("rst_rgb", {20'd0, Red, Green, Blue}, 32'd0);
      chk("rst_fs", {31'd0, frame_start}, 32'd0);
      chk("rst_err", {31'd0, cmd_err}, 32'd0);
      resetN = 1'b1;
      #20;

      // reset mid-RAMWR restores default window and cursor
      align();
      win(8'h2A, 16'd10, 16'd12);
      bus_wr(1'b0, 8'h2C);
      bus_wr(1'b1, 8'hF8);
      resetN = 1'b0;
      #25;
      resetN = 1'b1;
      #20;
      chk("rst2_none", 32'(px_x_q.size()), 32'd0);
      fs0 = fs_cnt;
      align();
      bus_wr(1'b0, 8'h2C);
      pix(16'hF800);
      settle();
      chk("rst2_fs", 32'(fs_cnt - fs0), 32'd1);
      pop_px("rst2_px", 0, 0, 12'hF00);

      // window set and raster wrap
      win(8'h2A, 16'd10, 16'd12);
      win(8'h2B, 16'd5, 16'd6);
      bus_wr(1'b0, 8'h2C);
      for (int i = 0; i < 7; i++) pix(16'h07E0);
      settle();
      for (int i = 0; i < 7; i++)
         pop_px($sformatf("win%0d", i), 10 + (i % 3), 5 + ((i / 3) % 2), 12'h0F0);

      // start beyond WIDTH rejected
      err0 = err_cnt;
      win(8'h2A, 16'h0140, 16'h0150);
      settle();
      chk("inv_err", 32'(err_cnt - err0), 32'd1);
      bus_wr(1'b0, 8'h2C);
      pix(16'hF800);
      settle();
      pop_px("inv_px", 10, 5, 12'hF00);

      // partial CASET aborted by RAMWR
      bus_wr(1'b0, 8'h2A);
      bus_wr(1'b1, 8'h00);
      bus_wr(1'b1, 8'h00);
      bus_wr(1'b0, 8'h2C);
      pix(16'h001E);
      settle();
      pop_px("abt_px", 10, 5, 12'h00F);

      // high byte then NOP: no pixel
      fs0 = fs_cnt;
      bus_wr(1'b0, 8'h2C);
      bus_wr(1'b1, 8'hFF);
      bus_wr(1'b0, 8'h00);
      settle();
      chk("nop_none", 32'(px_x_q.size()), 32'd0);
      chk("nop_fs", 32'(fs_cnt - fs0), 32'd1);

      // unknown command, its parameter and further data ignored
      err0 = err_cnt;
      bus_wr(1'b0, 8'h36);
      bus_wr(1'b1, 8'h48);
      bus_wr(1'b1, 8'h01);
      bus_wr(1'b1, 8'h02);
      settle();
      chk("unk_err", 32'(err_cnt - err0), 32'd1);
      chk("unk_none", 32'(px_x_q.size()), 32'd0);

      // minimum 2/2 strobe timing at a random phase, plus latency
      ph = $urandom_range(1, 9);
      align();
      bus_wr(1'b0, 8'h2C, 2, 2);
      pix(16'h001E, 2, 2);
      pix(16'h8410, 2, 2);
      pix(16'hFFFF, 2, 2);
      bus_wr(1'b1, 8'h12, 2, 2);
      lcd_d_c = 1'b1;
      lcd_db  = 8'h34;
      lcd_wr  = 1'b0;
      #20;
      lcd_wr  = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1 chk("lat_e1", {31'd0, pxl_valid}, 32'd0);
      @(posedge clk);
      #1 chk("lat_e2", {31'd0, pxl_valid}, 32'd1);
      #10;
      settle();
      pop_px("fast0", 10, 5, 12'h00F);
      pop_px("fast1", 11, 5, 12'h888);
      pop_px("fast2", 12, 5, 12'hFFF);
      pop_px("fast3", 10, 6, 12'h14A);

      // SWRESET restores default window
      align();
      bus_wr(1'b0, 8'h01);
      bus_wr(1'b0, 8'h2C);
      pix(16'hF800);
      pix(16'h0000);
      settle();
      pop_px("swr0", 0, 0, 12'hF00);
      pop_px("swr1", 1, 0, 12'h000);

      // panel reset clears outputs, window and cursor; writes ignored
      win(8'h2A, 16'd3, 16'd5);
      bus_wr(1'b0, 8'h2C);
      pix(16'hFFFF);
      settle();
      pop_px("prst_pre", 3, 0, 12'hFFF);
      lcd_reset = 1'b0;
      #40;
      chk("prst_x", pxl_x, 32'd0);
      chk("prst_y", pxl_y, 32'd0);
      chk("prst_rgb", {20'd0, Red, Green, Blue}, 32'd0);
      win(8'h2A, 16'd10, 16'd12);
      lcd_reset = 1'b1;
      #40;
      align();
      bus_wr(1'b0, 8'h2C);
      pix(16'h07E0);
      settle();
      pop_px("prst_post", 0, 0, 12'h0F0);
      chk("end_none", 32'(px_x_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
